// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop sync, stable-count debounce,
// and registered press / release / long-press pulses per channel.
module button_debouncer #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_BTN-1:0] raw_btn,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse
);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_chk
    $fatal(1, "button_debouncer: illegal DEBOUNCE_CYCLES/LONG_CYCLES");
  end

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

  // Bit 0 is the debounced level, bit 1 the long-press-done flag.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_HELD    = 2'b11
  } state_e;

  logic [NUM_BTN-1:0] s1_q;
  logic [NUM_BTN-1:0] s2_q;
  logic [DW-1:0]      cnt_q   [NUM_BTN];
  logic [DW-1:0]      cnt_d   [NUM_BTN];
  logic [HW-1:0]      hold_q  [NUM_BTN];
  logic [HW-1:0]      hold_d  [NUM_BTN];
  state_e             state_q [NUM_BTN];
  state_e             state_d [NUM_BTN];
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] press_d;
  logic [NUM_BTN-1:0] rel_q;
  logic [NUM_BTN-1:0] rel_d;
  logic [NUM_BTN-1:0] long_q;
  logic [NUM_BTN-1:0] long_d;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] accept;

  always_comb begin
    level = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      level[i] = (state_q[i] != ST_IDLE);
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    state_d = state_q;
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
    accept  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (s2_q[i] == level[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_MAX) begin
        cnt_d[i]  = '0;
        accept[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end

      unique case (state_q[i])
        ST_IDLE: begin
          hold_d[i] = '0;
          if (accept[i]) begin
            state_d[i] = ST_PRESSED;
            press_d[i] = 1'b1;
          end
        end
        ST_PRESSED: begin
          // An accepted fall on the same edge beats the long pulse.
          if (accept[i]) begin
            state_d[i] = ST_IDLE;
            hold_d[i]  = '0;
            rel_d[i]   = 1'b1;
          end else if (hold_q[i] == HOLD_MAX) begin
            state_d[i] = ST_HELD;
            long_d[i]  = 1'b1;
          end else begin
            hold_d[i] = hold_q[i] + HW'(1);
          end
        end
        ST_HELD: begin
          if (accept[i]) begin
            state_d[i] = ST_IDLE;
            hold_d[i]  = '0;
            rel_d[i]   = 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          hold_d[i]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i]   <= '0;
        hold_q[i]  <= '0;
        state_q[i] <= ST_IDLE;
      end
    end else begin
      s1_q    <= raw_btn;
      s2_q    <= s1_q;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i]   <= cnt_d[i];
        hold_q[i]  <= hold_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign btn_level     = level;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (D=4, L=8): every pulse
// observed is matched against a time-ordered list of predictions.
module tb_button_debouncer;

  localparam int NB = 4;
  localparam int LAT = 6;
  localparam int LONG = 8;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [NB-1:0] raw_btn;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;
  logic [NB-1:0] long_pulse;

  int unsigned cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  logic [47:0] sb[$];

  button_debouncer #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .raw_btn(raw_btn),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // kind: 1 press, 2 release, 3 long; key order matches monitor scan
  task automatic expect_ev(int unsigned cy, int k, int c);
    logic [47:0] e;
    int idx;
    e = {cy[31:0], 8'(k), 8'(c)};
    idx = sb.size();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i] > e) idx = i;
    end
    sb.insert(idx, e);
  endtask

  task automatic wait_cyc(int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic [NB-1:0] v;
    logic [47:0] got;
    #1;
    cyc = cyc + 1;
    for (int k = 1; k <= 3; k++) begin
      v = (k == 1) ? press_pulse : (k == 2) ? release_pulse : long_pulse;
      for (int c = 0; c < NB; c++) begin
        if (v[c] === 1'b1) begin
          got = {cyc[31:0], 8'(k), 8'(c)};
          if (sb.size() == 0) check("unexpected_ev", 64'(got), 64'd0);
          else check("event", 64'(got), 64'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    int unsigned p;
    n_rst = 1'b0;
    raw_btn = 4'hF;

    // 1. reset with all buttons held
    wait_cyc(2);
    check("rst_outs", 64'({btn_level, press_pulse, release_pulse, long_pulse}), 64'd0);
    n_rst = 1'b1;
    n = cyc;
    for (int c = 0; c < NB; c++) expect_ev(n + LAT, 1, c);
    for (int c = 0; c < NB; c++) expect_ev(n + LAT + LONG, 3, c);
    wait_cyc(n + LAT - 1);
    check("rst_lvl_pre", 64'(btn_level), 64'h0);
    wait_cyc(n + LAT);
    check("rst_lvl", 64'(btn_level), 64'hF);
    wait_cyc(n + 20);
    raw_btn = 4'h0;
    n = cyc;
    for (int c = 0; c < NB; c++) expect_ev(n + LAT, 2, c);
    wait_cyc(n + LAT);
    check("rel_all_lvl", 64'(btn_level), 64'h0);
    wait_cyc(n + 10);

    // 2. clean press ch0
    raw_btn[0] = 1'b1;
    n = cyc;
    expect_ev(n + LAT, 1, 0);
    expect_ev(n + LAT + LONG, 3, 0);
    wait_cyc(n + LAT - 1);
    check("c0_lvl_pre", 64'(btn_level[0]), 64'd0);
    wait_cyc(n + LAT);
    check("c0_lvl", 64'(btn_level[0]), 64'd1);
    wait_cyc(n + 16);
    raw_btn[0] = 1'b0;
    expect_ev(cyc + LAT, 2, 0);
    wait_cyc(cyc + 10);

    // glitch of 3 cycles never qualifies
    raw_btn[0] = 1'b1;
    wait_cyc(cyc + 3);
    raw_btn[0] = 1'b0;
    wait_cyc(cyc + 10);
    check("glitch_lvl", 64'(btn_level[0]), 64'd0);

    // 3. bounce on ch1
    n = cyc;
    for (int j = 0; j < 4; j++) begin
      raw_btn[1] = (j % 2 == 0);
      wait_cyc(n + 2 * (j + 1));
    end
    raw_btn[1] = 1'b1;
    n = cyc;
    expect_ev(n + LAT, 1, 1);
    expect_ev(n + LAT + LONG, 3, 1);
    wait_cyc(n + LAT - 1);
    check("c1_lvl_pre", 64'(btn_level[1]), 64'd0);
    wait_cyc(n + LAT);
    check("c1_lvl", 64'(btn_level[1]), 64'd1);
    wait_cyc(n + 18);
    raw_btn[1] = 1'b0;
    expect_ev(cyc + LAT, 2, 1);
    wait_cyc(cyc + 10);

    // 4. long press ch2 held 30 cycles
    raw_btn[2] = 1'b1;
    n = cyc;
    expect_ev(n + LAT, 1, 2);
    expect_ev(n + LAT + LONG, 3, 2);
    wait_cyc(n + 30);
    raw_btn[2] = 1'b0;
    expect_ev(cyc + LAT, 2, 2);
    wait_cyc(cyc + LAT);
    check("c2_lvl_rel", 64'(btn_level[2]), 64'd0);
    wait_cyc(cyc + 4);

    // 5. short press ch3: fall lands on the would-be long edge
    raw_btn[3] = 1'b1;
    n = cyc;
    expect_ev(n + LAT, 1, 3);
    wait_cyc(n + 8);
    raw_btn[3] = 1'b0;
    expect_ev(cyc + LAT, 2, 3);
    wait_cyc(cyc + 14);

    // simultaneous press ch0 + ch3
    raw_btn = 4'b1001;
    n = cyc;
    expect_ev(n + LAT, 1, 0);
    expect_ev(n + LAT, 1, 3);
    expect_ev(n + LAT + LONG, 3, 0);
    expect_ev(n + LAT + LONG, 3, 3);
    wait_cyc(n + LAT);
    check("sim_lvl", 64'(btn_level), 64'h9);
    wait_cyc(n + 20);
    raw_btn = 4'h0;
    expect_ev(cyc + LAT, 2, 0);
    expect_ev(cyc + LAT, 2, 3);
    wait_cyc(cyc + 12);

    // 6. reset with ch2 hold counter at 5
    raw_btn[2] = 1'b1;
    n = cyc;
    p = n + LAT;
    expect_ev(p, 1, 2);
    wait_cyc(p + 5);
    n_rst = 1'b0;
    wait_cyc(p + 6);
    check("mid_rst_outs", 64'({btn_level, press_pulse, release_pulse, long_pulse}), 64'd0);
    n_rst = 1'b1;
    n = cyc;
    expect_ev(n + LAT, 1, 2);
    expect_ev(n + LAT + LONG, 3, 2);
    wait_cyc(n + LAT - 1);
    check("c2_re_pre", 64'(btn_level[2]), 64'd0);
    wait_cyc(n + LAT);
    check("c2_re_lvl", 64'(btn_level[2]), 64'd1);
    wait_cyc(n + 20);
    raw_btn[2] = 1'b0;
    expect_ev(cyc + LAT, 2, 2);
    wait_cyc(cyc + 12);

    check("final_lvl", 64'(btn_level), 64'h0);
    check("sb_left", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
